bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

MM:SS countdown timer built from cascaded BCD down-counters with borrow. It is the decrementing counterpart of the team's wrapping up-counter and mod-N digit counters. It loads a BCD start value and counts down one step per prescaled tick. It pulses `done` on reaching 00:00, and sits beside the up-counting clock datapath, feeding the same 7-segment display path.

## Interface
- `TICK_DIV`, default 100: clk cycles per one-second tick; must be ≥ 2.
- `clk` input 1: system clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `load` input 1: one-cycle request to load `load_value`.
- `load_value` input 16: BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `start` input 1: one-cycle request to begin or resume counting.
- `pause` input 1: one-cycle request to suspend counting.
- `clear` input 1: synchronous return to 00:00 and IDLE.
- `count` output 16: current BCD value, same digit order as `load_value`.
- `running` output 1: high in RUN.
- `done` output 1: one-cycle pulse when the count reaches 00:00 from RUN.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED. Reset gives IDLE, `count`=0, `running`=0, `done`=0, `load_err`=0, prescaler=0.
- Command priority within one cycle: `clear` > `load` > `start` > `pause`. Lower-priority commands in the same cycle are ignored.
- `clear`, from any state: `count`←0, prescaler←0, go to IDLE.
- `load`, from any state:
  - Valid BCD means each ones digit ≤ 9 and each tens digit ≤ 5.
  - If valid: `count`←`load_value`, prescaler←0, go to IDLE.
  - If invalid: `count` and state are unchanged, and `load_err` pulses.
- `start`:
  - From IDLE or PAUSED with `count`≠0: go to RUN.
  - From IDLE, the prescaler is cleared. From PAUSED, the prescaler keeps its partial value.
  - Ignored when `count`=0, in RUN, or in EXPIRED.
- `pause`: RUN→PAUSED. Ignored in all other states.
- In RUN, the prescaler counts 0..TICK_DIV-1 and wraps. A tick occurs on the cycle it wraps.
- On a tick, `count` decrements by one second with borrow:
  - sec_ones 0→9 and borrows into sec_tens.
  - sec_tens 0→5 and borrows into min_ones.
  - min_ones 0→9 and borrows into min_tens.
  - min_tens 0→5 is unreachable, because a tick never occurs at 00:00.
- If the tick takes `count` from 00:01 to 00:00: state→EXPIRED, and `done` pulses in the same cycle the 00:00 value becomes visible.
- EXPIRED holds 00:00. It is left only by `load` or `clear`.
- A tick and `pause` in the same cycle: `pause` wins. No decrement occurs, and the prescaler holds at TICK_DIV-1.
- A tick and `clear` or `load` in the same cycle: the command wins and no decrement occurs.
- Reset mid-operation: immediately returns to the reset values listed above, regardless of state.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- `start` is sampled at edge k. `running` is high after edge k.
- From IDLE, the first decrement is visible after edge k+TICK_DIV. Subsequent decrements follow every TICK_DIV cycles.
- Load: `count` updates after the sampling edge, with 1-cycle latency. `load_err` has the same latency.
- `done` is high for exactly one cycle per expiry.
- Prescaler width is ceil(log2(TICK_DIV)).

## Structure
- Shared package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSED, EXPIRED);
  - digit moduli constants SEC_ONES_MOD=10, SEC_TENS_MOD=6, MIN_ONES_MOD=10, MIN_TENS_MOD=6;
  - BCD digit width of 4.
- Sub-module `bcd_down_digit`, instantiated four times:
  - Parameter: `MOD`.
  - Inputs: clk, reset_n, `dec`, `load`, `load_digit`.
  - Outputs: `digit` and a combinational `borrow` (`dec` && `digit`==0). Borrow chains to the next digit's `dec`.
  - On `dec` at 0 the digit wraps to MOD-1.
- The top level holds the FSM, prescaler, BCD validity check and expiry detection.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then load 0x0012, then start: `running` is high next cycle and `count` is 0x0011 after 4 cycles. Mid-run reset_n low gives `count`=0 and IDLE asynchronously.
- Load 0x0100, then start: after one tick `count`=0x0059, showing the borrow across sec_ones, sec_tens and min_ones.
- Load 0x0002 and run: after 2 ticks `count`=0x0000 and `done` is high exactly 1 cycle. After that, `start` is ignored and `running` stays 0.
- Load 0x0070, whose sec_tens digit is 7: `load_err` pulses 1 cycle and `count` keeps its previous value. Load 0x000A gives the same result.
- In RUN, assert `pause` 2 cycles into a tick period, wait 10 cycles, then `start`: the next decrement comes 2 cycles after the resume, and `count` does not change while PAUSED.
- Assert `pause` on the tick cycle: no decrement. Assert `clear`, `load` and `start` together: `count`=0 and IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, digit moduli
// and the MM:SS validity check used on load.
package timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;
    localparam int MIN_ONES_MOD = 10;
    localparam int MIN_TENS_MOD = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } timer_state_t;

    // Digit index 0 is sec_ones, 3 is min_tens.
    function automatic int digit_mod(input int idx);
        case (idx)
            0:       return SEC_ONES_MOD;
            1:       return SEC_TENS_MOD;
            2:       return MIN_ONES_MOD;
            default: return MIN_TENS_MOD;
        endcase
    endfunction

    function automatic logic bcd_time_valid(input logic [4*BCD_W-1:0] v);
        return (v[3:0]   < 4'(SEC_ONES_MOD)) &&
               (v[7:4]   < 4'(SEC_TENS_MOD)) &&
               (v[11:8]  < 4'(MIN_ONES_MOD)) &&
               (v[15:12] < 4'(MIN_TENS_MOD));
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load; wraps 0 -> MOD-1 and
// raises a combinational borrow for the next more significant digit.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dec,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] digit,
    output logic             borrow
);

    logic [BCD_W-1:0] digit_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= load_digit;
        end else if (dec) begin
            digit_reg <= (digit_reg == '0) ? BCD_W'(MOD - 1) : digit_reg - BCD_W'(1);
        end
    end

    assign digit  = digit_reg;
    assign borrow = dec && (digit_reg == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: command decode, FSM, one-second prescaler and
// expiry detection around a chain of four BCD down-digits.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [4*BCD_W-1:0]   load_value,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    output logic [4*BCD_W-1:0]   count,
    output logic                 running,
    output logic                 done,
    output logic                 load_err
);

    localparam int PW = $clog2(TICK_DIV);

    timer_state_t  state_reg, state_next;
    logic [PW-1:0] prescale_reg, prescale_next;
    logic          done_reg, done_next;
    logic          load_err_reg, load_err_next;
    logic          running_reg;

    logic          load_ok, start_ok, pause_ok, run_step, tick;
    logic          digit_load;
    logic [4:0]    dec_chain;

    // Commands resolved by priority: clear > load > start > pause.
    assign load_ok  = !clear && load && bcd_time_valid(load_value);
    assign start_ok = !clear && !load && start && (count != '0) &&
                      ((state_reg == IDLE) || (state_reg == PAUSED));
    assign pause_ok = !clear && !load && !start && pause && (state_reg == RUN);
    assign run_step = (state_reg == RUN) && !clear && !load && !pause_ok;
    assign tick     = run_step && (prescale_reg == PW'(TICK_DIV - 1));

    assign digit_load   = clear || load_ok;
    assign dec_chain[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            bcd_down_digit #(
                .MOD(digit_mod(gi))
            ) u_digit (
                .clk       (clk),
                .reset_n   (reset_n),
                .dec       (dec_chain[gi]),
                .load      (digit_load),
                .load_digit(clear ? '0 : load_value[gi*BCD_W +: BCD_W]),
                .digit     (count[gi*BCD_W +: BCD_W]),
                .borrow    (dec_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        prescale_next = prescale_reg;
        done_next     = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            state_next    = IDLE;
            prescale_next = '0;
        end else if (load) begin
            if (load_ok) begin
                state_next    = IDLE;
                prescale_next = '0;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (start_ok) begin
            state_next = RUN;
            if (state_reg == IDLE) begin
                prescale_next = '0;
            end
        end else if (pause_ok) begin
            state_next = PAUSED;
        end else if (run_step) begin
            if (tick) begin
                prescale_next = '0;
                // Borrow out of min_tens would mean ticking at 00:00; treat as expiry.
                if ((count == 16'h0001) || dec_chain[4]) begin
                    state_next = EXPIRED;
                    done_next  = 1'b1;
                end
            end else begin
                prescale_next = prescale_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            done_reg     <= 1'b0;
            load_err_reg <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prescale_reg <= prescale_next;
            done_reg     <= done_next;
            load_err_reg <= load_err_next;
            running_reg  <= (state_next == RUN);
        end
    end

    assign running  = running_reg;
    assign done     = done_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with TICK_DIV=4: expected outputs
// are queued with each stimulus and compared after the sampling edge.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] count;
    logic        running, done, load_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .count     (count),
        .running   (running),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] out_sel(input int sel);
        case (sel)
            0:       return count;
            1:       return {15'b0, running};
            2:       return {15'b0, done};
            default: return {15'b0, load_err};
        endcase
    endfunction

    task automatic push_exp(input string tag, input logic [15:0] c, input logic r,
                            input logic d, input logic e);
        sb.push_back('{{tag, ".count"},    0, c});
        sb.push_back('{{tag, ".running"},  1, {15'b0, r}});
        sb.push_back('{{tag, ".done"},     2, {15'b0, d}});
        sb.push_back('{{tag, ".load_err"}, 3, {15'b0, e}});
    endtask

    task automatic score(input string tag);
        exp_t e;
        $display("[%0t] %s count=%h running=%b done=%b load_err=%b",
                 $time, tag, count, running, done, load_err);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, out_sel(e.sel), e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int n, input logic [15:0] c,
                            input logic r, input logic d, input logic e);
        push_exp(tag, c, r, d, e);
        cyc(n);
        score(tag);
    endtask

    task automatic cmd_chk(input string tag, input logic ld, input logic [15:0] lv,
                           input logic st, input logic pa, input logic cl,
                           input logic [15:0] c, input logic r, input logic d, input logic e);
        push_exp(tag, c, r, d, e);
        load = ld; load_value = lv; start = st; pause = pa; clear = cl;
        cyc(1);
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        score(tag);
    endtask

    initial begin
        cyc(2);
        push_exp("reset", 16'h0000, 0, 0, 0);
        score("reset");
        reset_n = 1'b1;
        cyc(1);

        // Basic load/start and first-tick latency
        cmd_chk("s1_load",  1, 16'h0012, 0, 0, 0, 16'h0012, 0, 0, 0);
        cmd_chk("s1_start", 0, 16'h0000, 1, 0, 0, 16'h0012, 1, 0, 0);
        step_chk("s1_pre",  3, 16'h0012, 1, 0, 0);
        step_chk("s1_tick", 1, 16'h0011, 1, 0, 0);
        step_chk("s1_run",  1, 16'h0011, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1 push_exp("s1_async_rst", 16'h0000, 0, 0, 0);
        score("s1_async_rst");
        #2 reset_n = 1'b1;

        // Borrow across three digits, then load while running
        cmd_chk("s2_load",  1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0);
        cmd_chk("s2_start", 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0);
        step_chk("s2_tick1", 4, 16'h0059, 1, 0, 0);
        step_chk("s2_tick2", 4, 16'h0058, 1, 0, 0);

        // Expiry and done pulse
        cmd_chk("s3_load",  1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0);
        cmd_chk("s3_start", 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0);
        step_chk("s3_tick1", 4, 16'h0001, 1, 0, 0);
        step_chk("s3_pre",   3, 16'h0001, 1, 0, 0);
        step_chk("s3_expire", 1, 16'h0000, 0, 1, 0);
        step_chk("s3_after", 1, 16'h0000, 0, 0, 0);
        cmd_chk("s3_start_ign", 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);
        step_chk("s3_hold", 4, 16'h0000, 0, 0, 0);

        // Load validity
        cmd_chk("s4_load_ok",  1, 16'h0035, 0, 0, 0, 16'h0035, 0, 0, 0);
        cmd_chk("s4_bad_70",   1, 16'h0070, 0, 0, 0, 16'h0035, 0, 0, 1);
        step_chk("s4_err_end", 1, 16'h0035, 0, 0, 0);
        cmd_chk("s4_bad_0A",   1, 16'h000A, 0, 0, 0, 16'h0035, 0, 0, 1);
        cmd_chk("s4_bad_6000", 1, 16'h6000, 0, 0, 0, 16'h0035, 0, 0, 1);
        cmd_chk("s4_max",      1, 16'h5959, 0, 0, 0, 16'h5959, 0, 0, 0);

        // Pause mid-period keeps the partial prescaler
        cmd_chk("s5_start", 0, 16'h0000, 1, 0, 0, 16'h5959, 1, 0, 0);
        step_chk("s5_tick", 4, 16'h5958, 1, 0, 0);
        step_chk("s5_mid",  2, 16'h5958, 1, 0, 0);
        cmd_chk("s5_pause", 0, 16'h0000, 0, 1, 0, 16'h5958, 0, 0, 0);
        step_chk("s5_paused", 10, 16'h5958, 0, 0, 0);
        cmd_chk("s5_resume", 0, 16'h0000, 1, 0, 0, 16'h5958, 1, 0, 0);
        step_chk("s5_r1", 1, 16'h5958, 1, 0, 0);
        step_chk("s5_r2", 1, 16'h5957, 1, 0, 0);

        // Pause on the tick cycle, then combined commands
        step_chk("s6_pre", 3, 16'h5957, 1, 0, 0);
        cmd_chk("s6_pause_tick", 0, 16'h0000, 0, 1, 0, 16'h5957, 0, 0, 0);
        step_chk("s6_paused", 3, 16'h5957, 0, 0, 0);
        cmd_chk("s6_resume", 0, 16'h0000, 1, 0, 0, 16'h5957, 1, 0, 0);
        step_chk("s6_tick", 1, 16'h5956, 1, 0, 0);
        cmd_chk("s6_clr_ld_st", 1, 16'h1234, 1, 0, 1, 16'h0000, 0, 0, 0);
        cmd_chk("s6_start_zero", 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);

        // Borrow into min_tens
        cmd_chk("s7_load",  1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
        cmd_chk("s7_start", 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0);
        step_chk("s7_tick", 4, 16'h0959, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
